hssl_link_manager: RTL and testbench

//  Per-lane reset sequencer and link-state monitor for NUM_LANES HSSL transceiver lanes.

---
 rtl/hssl_link_manager_if.sv | 28 ++
 rtl/hssl_link_manager.sv | 171 +++++++++++++++++
 tb/tb_hssl_link_manager.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/hssl_link_manager_if.sv
// rtl/hssl_link_manager_if.sv - per-lane transceiver status/control bundle for hssl_link_manager
interface hssl_link_manager_if #(
   parameter int NUM_LANES = 4,
   parameter int CNT_W     = 8
);
   logic [NUM_LANES-1:0]       tx_reset_done_in;
   logic [NUM_LANES-1:0]       rx_reset_done_in;
   logic [NUM_LANES-1:0]       rx_commadet_in;
   logic [NUM_LANES-1:0]       rx_err_in;
   logic [NUM_LANES-1:0]       lane_retrain_in;
   logic [NUM_LANES-1:0]       tx_reset_datapath_out;
   logic [NUM_LANES-1:0]       rx_reset_datapath_out;
   logic [NUM_LANES-1:0]       link_up_out;
   logic                       all_up_out;
   logic [NUM_LANES*CNT_W-1:0] retrain_count_out;

   modport master (
      output tx_reset_done_in, rx_reset_done_in, rx_commadet_in, rx_err_in, lane_retrain_in,
      input  tx_reset_datapath_out, rx_reset_datapath_out, link_up_out, all_up_out,
             retrain_count_out
   );

   modport slave (
      input  tx_reset_done_in, rx_reset_done_in, rx_commadet_in, rx_err_in, lane_retrain_in,
      output tx_reset_datapath_out, rx_reset_datapath_out, link_up_out, all_up_out,
             retrain_count_out
   );
endinterface

// File: rtl/hssl_link_manager.sv
// rtl/hssl_link_manager.sv - per-lane HSSL reset sequencer and link-state monitor
// Each lane runs an independent FSM; only all_up_out combines lanes.
module hssl_link_manager #(
   parameter int NUM_LANES     = 4,
   parameter int RST_PULSE     = 16,
   parameter int DONE_TIMEOUT  = 100000,
   parameter int ALIGN_CLEAN   = 1024,
   parameter int ERR_WINDOW    = 4096,
   parameter int ERR_THRESHOLD = 8,
   parameter int CNT_W         = 8
) (
   input  logic               freerun_clk_in,
   input  logic               reset_all_in,
   hssl_link_manager_if.slave lnk
);
   localparam int TMR_A   = (DONE_TIMEOUT > ERR_WINDOW) ? DONE_TIMEOUT : ERR_WINDOW;
   localparam int TMR_MAX = (TMR_A > RST_PULSE) ? TMR_A : RST_PULSE;
   localparam int TW      = $clog2(TMR_MAX + 1);
   localparam int CW      = $clog2(ALIGN_CLEAN + 1);
   localparam int EW      = $clog2(ERR_THRESHOLD + 2);

   localparam logic [TW-1:0]    PULSE_END   = TW'(RST_PULSE - 1);
   localparam logic [TW-1:0]    TIMEOUT_END = TW'(DONE_TIMEOUT - 1);
   localparam logic [TW-1:0]    WINDOW_END  = TW'(ERR_WINDOW - 1);
   localparam logic [CW-1:0]    CLEAN_END   = CW'(ALIGN_CLEAN);
   localparam logic [EW-1:0]    ERR_MAX     = EW'(ERR_THRESHOLD + 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [2:0] {TX_RST, TX_WAIT, RX_RST, RX_WAIT, ALIGN, UP} lane_state_e;

   logic [NUM_LANES-1:0] link_up_vec;
   logic                 all_up_q, all_up_d;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_state_e      state_q, state_d;
      logic [TW-1:0]    timer_q, timer_d;
      logic [CW-1:0]    clean_q, clean_d;
      logic [EW-1:0]    err_cnt_q, err_cnt_d;
      logic             comma_q, comma_d;
      logic [CNT_W-1:0] retrain_q, retrain_d;
      logic             tx_rst_q, rx_rst_q, up_q;
      logic             retrain, entry;
      logic             tx_done, rx_done, commadet, err, force_rt;

      assign tx_done  = lnk.tx_reset_done_in[g];
      assign rx_done  = lnk.rx_reset_done_in[g];
      assign commadet = lnk.rx_commadet_in[g];
      assign err      = lnk.rx_err_in[g];
      assign force_rt = lnk.lane_retrain_in[g];

      always_comb begin
         state_d   = state_q;
         timer_d   = timer_q + 1'b1;
         clean_d   = clean_q;
         err_cnt_d = err_cnt_q;
         comma_d   = comma_q;
         retrain   = 1'b0;
         unique case (state_q)
            TX_RST: begin
               if (timer_q == PULSE_END) state_d = TX_WAIT;
            end
            TX_WAIT: begin
               if (tx_done)                     state_d = RX_RST;
               else if (timer_q == TIMEOUT_END) state_d = TX_RST;
            end
            RX_RST: begin
               if (timer_q == PULSE_END) state_d = RX_WAIT;
            end
            RX_WAIT: begin
               if (rx_done) begin
                  state_d = ALIGN;
               end else if (timer_q == TIMEOUT_END) begin
                  state_d = RX_RST;
                  retrain = 1'b1;
               end
            end
            ALIGN: begin
               comma_d = comma_q | commadet;
               if (err)                     clean_d = '0;
               else if (clean_q != CLEAN_END) clean_d = clean_q + 1'b1;
               if (comma_d && (clean_d == CLEAN_END)) begin
                  state_d = UP;
               end else if (timer_q == TIMEOUT_END) begin
                  state_d = RX_RST;
                  retrain = 1'b1;
               end
            end
            UP: begin
               // An error on the wrap cycle opens the new window at 1.
               if (timer_q == WINDOW_END) begin
                  timer_d   = '0;
                  err_cnt_d = EW'(err);
               end else if (err && (err_cnt_q != ERR_MAX)) begin
                  err_cnt_d = err_cnt_q + 1'b1;
               end
               if (err_cnt_d == ERR_MAX) begin
                  state_d = RX_RST;
                  retrain = 1'b1;
               end
            end
            default: state_d = TX_RST;
         endcase

         if (state_q inside {RX_RST, RX_WAIT, ALIGN, UP}) begin
            if (!tx_done) begin
               state_d = TX_RST;
               retrain = 1'b0;
            end else if (force_rt) begin
               state_d = RX_RST;
               retrain = 1'b1;
            end else if ((state_q inside {ALIGN, UP}) && !rx_done) begin
               state_d = RX_WAIT;
               retrain = 1'b1;
            end
         end

         // A retrain from RX_RST back into RX_RST is still a fresh entry.
         entry = (state_d != state_q) || retrain;
         if (entry) begin
            timer_d   = '0;
            clean_d   = '0;
            err_cnt_d = '0;
            comma_d   = 1'b0;
         end

         retrain_d = retrain_q;
         if (retrain && (retrain_q != CNT_MAX)) retrain_d = retrain_q + 1'b1;
      end

      always_ff @(posedge freerun_clk_in) begin
         if (reset_all_in) begin
            state_q   <= TX_RST;
            timer_q   <= '0;
            clean_q   <= '0;
            err_cnt_q <= '0;
            comma_q   <= 1'b0;
            retrain_q <= '0;
            tx_rst_q  <= 1'b1;
            rx_rst_q  <= 1'b1;
            up_q      <= 1'b0;
         end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            clean_q   <= clean_d;
            err_cnt_q <= err_cnt_d;
            comma_q   <= comma_d;
            retrain_q <= retrain_d;
            tx_rst_q  <= (state_d == TX_RST);
            rx_rst_q  <= (state_d inside {TX_RST, RX_RST});
            up_q      <= (state_d == UP);
         end
      end

      assign lnk.tx_reset_datapath_out[g]          = tx_rst_q;
      assign lnk.rx_reset_datapath_out[g]          = rx_rst_q;
      assign link_up_vec[g]                        = up_q;
      assign lnk.retrain_count_out[g*CNT_W +: CNT_W] = retrain_q;
   end

   always_comb begin
      all_up_d = &link_up_vec;
   end

   always_ff @(posedge freerun_clk_in) begin
      if (reset_all_in) all_up_q <= 1'b0;
      else              all_up_q <= all_up_d;
   end

   assign lnk.link_up_out = link_up_vec;
   assign lnk.all_up_out  = all_up_q;
endmodule

// File: tb/tb_hssl_link_manager.sv
// tb/tb_hssl_link_manager.sv - directed bench for hssl_link_manager with shortened timing parameters
module tb_hssl_link_manager;
   localparam int NL = 4;
   localparam int P  = 4;
   localparam int DT = 200;
   localparam int AC = 32;
   localparam int EWIN = 64;
   localparam int THR = 8;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic up_drop;

   always #5 clk = ~clk;

   hssl_link_manager_if #(.NUM_LANES(NL), .CNT_W(CW)) lnk ();

   hssl_link_manager #(
      .NUM_LANES(NL), .RST_PULSE(P), .DONE_TIMEOUT(DT), .ALIGN_CLEAN(AC),
      .ERR_WINDOW(EWIN), .ERR_THRESHOLD(THR), .CNT_W(CW)
   ) dut (
      .freerun_clk_in(clk),
      .reset_all_in  (rst),
      .lnk           (lnk)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      lnk.tx_reset_done_in = '1;
      lnk.rx_reset_done_in = '1;
      lnk.rx_commadet_in   = '0;
      lnk.rx_err_in        = '0;
      lnk.lane_retrain_in  = '0;

      // Test 1: bring-up from reset
      step(4);
      chk("rst_tx", lnk.tx_reset_datapath_out, 4'hF);
      chk("rst_rx", lnk.rx_reset_datapath_out, 4'hF);
      chk("rst_up", lnk.link_up_out, 4'h0);
      chk("rst_all", lnk.all_up_out, 1'b0);
      chk("rst_cnt", lnk.retrain_count_out, 32'h0);
      rst = 1'b0;
      step(P - 1);                                   // e3
      chk("t1_tx_held", lnk.tx_reset_datapath_out, 4'hF);
      step(1);                                       // e4 TX_WAIT
      chk("t1_tx_rel", lnk.tx_reset_datapath_out, 4'h0);
      chk("t1_rx_txwait", lnk.rx_reset_datapath_out, 4'h0);
      step(1);                                       // e5 RX_RST
      chk("t1_rx_rst", lnk.rx_reset_datapath_out, 4'hF);
      step(P);                                       // e9 RX_WAIT
      chk("t1_rx_rel", lnk.rx_reset_datapath_out, 4'h0);
      step(1);                                       // e10 ALIGN entry
      lnk.rx_commadet_in = '1;
      step(1);                                       // e11
      lnk.rx_commadet_in = '0;
      step(AC - 2);                                  // e41
      chk("t1_up_early", lnk.link_up_out, 4'h0);
      step(1);                                       // e42 UP
      chk("t1_up", lnk.link_up_out, 4'hF);
      chk("t1_all_lag", lnk.all_up_out, 1'b0);
      step(1);                                       // e43
      chk("t1_all_up", lnk.all_up_out, 1'b1);

      // Test 2: lane 2 gets 9 errors inside one window
      lnk.rx_err_in = 4'b0100;
      step(THR);                                     // e51, 8 errors
      chk("t2_8err_up", lnk.link_up_out, 4'hF);
      step(1);                                       // e52, 9th error
      lnk.rx_err_in = '0;
      chk("t2_9err_down", lnk.link_up_out, 4'b1011);
      chk("t2_rx_rst", lnk.rx_reset_datapath_out, 4'b0100);
      chk("t2_cnt", lnk.retrain_count_out, 32'h0001_0000);
      lnk.rx_commadet_in = 4'b0100;
      step(46);                                      // e98, lane 2 back up at e89
      lnk.rx_commadet_in = '0;
      chk("t2_relink", lnk.link_up_out, 4'hF);

      // Test 3: lane 0, 8 errors per window incl. wrap cycle, 10 windows (wraps at e106+64k)
      up_drop = 1'b0;
      for (int e = 99; e <= 745; e++) begin
         lnk.rx_err_in[0] = (e >= 106) && ((((e - 106) % EWIN) == 0) || (((e - 106) % EWIN) >= 57));
         step(1);
         if (lnk.link_up_out[0] !== 1'b1) up_drop = 1'b1;
      end
      lnk.rx_err_in = '0;
      chk("t3_no_drop", up_drop, 1'b0);
      chk("t3_up", lnk.link_up_out, 4'hF);
      chk("t3_cnt", lnk.retrain_count_out, 32'h0001_0000);

      // Test 4: lane 3 loses tx_reset_done; TX_WAIT times out three times
      lnk.tx_reset_done_in = 4'b0111;
      step(1);                                       // e746
      chk("t4_down", lnk.link_up_out, 4'b0111);
      chk("t4_tx_rst", lnk.tx_reset_datapath_out, 4'b1000);
      step(P);                                       // e750 TX_WAIT
      chk("t4_tx_wait", lnk.tx_reset_datapath_out, 4'b0000);
      step(DT - 1);                                  // e949
      chk("t4_before_to", lnk.tx_reset_datapath_out, 4'b0000);
      step(1);                                       // e950
      chk("t4_timeout1", lnk.tx_reset_datapath_out, 4'b1000);
      step(2 * (P + DT) - 1);                        // e1357
      chk("t4_before_to3", lnk.tx_reset_datapath_out, 4'b0000);
      step(1);                                       // e1358
      chk("t4_timeout3", lnk.tx_reset_datapath_out, 4'b1000);
      chk("t4_cnt", lnk.retrain_count_out, 32'h0001_0000);

      // Test 5a: lane 3 in ALIGN, error at clean count AC-1 restarts the count
      lnk.tx_reset_done_in = '1;
      lnk.rx_commadet_in = 4'b1000;
      step(41);                                      // e1399, ALIGN since e1368
      lnk.rx_err_in = 4'b1000;
      step(1);                                       // e1400
      lnk.rx_err_in = '0;
      chk("t5_err_blocks", lnk.link_up_out, 4'b0111);
      step(AC - 1);                                  // e1431
      chk("t5_restart", lnk.link_up_out, 4'b0111);
      step(1);                                       // e1432
      chk("t5_up", lnk.link_up_out, 4'hF);
      lnk.rx_commadet_in = '0;

      // Test 5b: lane 1 forced retrain, then no comma -> ALIGN timeout
      lnk.lane_retrain_in = 4'b0010;
      step(1);                                       // e1433
      lnk.lane_retrain_in = '0;
      chk("t5_force_down", lnk.link_up_out, 4'b1101);
      chk("t5_force_cnt", lnk.retrain_count_out, 32'h0001_0100);
      step(204);                                     // e1637, ALIGN since e1438
      chk("t5_align_wait", lnk.rx_reset_datapath_out, 4'b0000);
      step(1);                                       // e1638
      chk("t5_align_to", lnk.rx_reset_datapath_out, 4'b0010);
      chk("t5_to_cnt", lnk.retrain_count_out, 32'h0001_0200);

      // Test 5c: 300 forced retrains saturate lane 1's counter
      for (int i = 0; i < 252; i++) begin
         lnk.lane_retrain_in = 4'b0010;
         step(1);
         lnk.lane_retrain_in = '0;
         step(1);
      end
      chk("t5_cnt_254", lnk.retrain_count_out, 32'h0001_FE00);
      for (int i = 0; i < 48; i++) begin
         lnk.lane_retrain_in = 4'b0010;
         step(1);
         lnk.lane_retrain_in = '0;
         step(1);
      end
      chk("t5_cnt_sat", lnk.retrain_count_out, 32'h0001_FF00);

      // Test 6: reset_all_in while every lane is up
      lnk.rx_commadet_in = 4'b0010;
      step(60);
      lnk.rx_commadet_in = '0;
      chk("t6_all_lanes", lnk.link_up_out, 4'hF);
      step(1);
      chk("t6_all_up", lnk.all_up_out, 1'b1);
      rst = 1'b1;
      step(1);
      chk("t6_rst_tx", lnk.tx_reset_datapath_out, 4'hF);
      chk("t6_rst_rx", lnk.rx_reset_datapath_out, 4'hF);
      chk("t6_rst_up", lnk.link_up_out, 4'h0);
      chk("t6_rst_all", lnk.all_up_out, 1'b0);
      chk("t6_rst_cnt", lnk.retrain_count_out, 32'h0);
      rst = 1'b0;
      lnk.rx_commadet_in = '1;
      step(2 * P + 2 + AC - 1);
      chk("t6_up_early", lnk.link_up_out, 4'h0);
      step(1);
      chk("t6_up", lnk.link_up_out, 4'hF);
      step(1);
      chk("t6_all_up2", lnk.all_up_out, 1'b1);
      lnk.rx_commadet_in = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
